// File: rtl/stage_ma_hs_pkg.sv
// Shared pipeline definitions: opcode field width, opcode values, stage states.
package stage_ma_hs_pkg;

  localparam int unsigned OPC_W = 8;

  typedef logic [OPC_W-1:0] opc_t;

  localparam opc_t OPC_ADD   = 8'h01;
  localparam opc_t OPC_SUB   = 8'h02;
  localparam opc_t OPC_AND   = 8'h03;
  localparam opc_t OPC_OR    = 8'h04;
  localparam opc_t OPC_LD    = 8'h10;
  localparam opc_t OPC_LDI   = 8'h11;
  localparam opc_t OPC_ST    = 8'h12;
  localparam opc_t OPC_STI   = 8'h13;
  localparam opc_t OPC_BCC   = 8'h20;
  localparam opc_t OPC_BCCI  = 8'h21;
  localparam opc_t OPC_BCCIS = 8'h22;
  localparam opc_t OPC_SRBCC = 8'h23;

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    HOLD
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } op_class_e;

  // Map an opcode to its execution class; unknown opcodes behave as ALU ops.
  function automatic op_class_e op_class(input opc_t opc);
    case (opc)
      OPC_LD, OPC_LDI:                          return CLS_LOAD;
      OPC_ST, OPC_STI:                          return CLS_STORE;
      OPC_BCC, OPC_BCCI, OPC_BCCIS, OPC_SRBCC:  return CLS_BRANCH;
      default:                                  return CLS_ALU;
    endcase
  endfunction

endpackage

// File: rtl/stage_ma_hs_pipe_reg.sv
// Output register slice: holds its payload while valid and not accepted downstream.
module pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic         out_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  // Valid flag: flush wins, then a refill, then a downstream drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           out_valid <= 1'b0;
    else if (flush)     out_valid <= 1'b0;
    else if (load)      out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  // Payload only changes on a load, so it stays frozen while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      out_data <= '0;
    else if (load) out_data <= in_data;
  end

endmodule

// File: rtl/stage_ma_hs.sv
// Memory-access pipeline stage with valid/ready handshake and a single
// outstanding data-memory request.
module stage_ma_hs #(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned FLAGS_W = 4,
  parameter int unsigned OPC_W   = stage_ma_hs_pkg::OPC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic [DATA_W-1:0]  pc_in,
  input  logic [DATA_W-1:0]  instr_in,
  input  logic [DATA_W-1:0]  result_in,
  input  logic [DATA_W-1:0]  store_data_in,
  input  logic [FLAGS_W-1:0] flags_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  pc_out,
  output logic [DATA_W-1:0]  instr_out,
  output logic [DATA_W-1:0]  result_out,
  output logic [DATA_W-1:0]  store_data_out,
  output logic [FLAGS_W-1:0] flags_out,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata
);

  import stage_ma_hs_pkg::*;

  localparam int unsigned PAY_W = 4 * DATA_W + FLAGS_W;

  state_e              state_q, state_d;
  logic                alive_q;
  logic                discard_q;
  logic                pend_load_q;
  logic [DATA_W-1:0]   pend_pc_q, pend_instr_q, pend_sd_q;
  logic [FLAGS_W-1:0]  pend_flags_q;
  op_class_e           cls;
  logic                is_mem, xfer;
  logic                slot_load;
  logic [PAY_W-1:0]    slot_d, slot_q;

  assign cls      = op_class(opc_t'(instr_in[DATA_W-1 -: OPC_W]));
  assign is_mem   = (cls == CLS_LOAD) || (cls == CLS_STORE);
  // alive_q keeps in_ready low during reset and until the first clock after release
  assign in_ready = alive_q && (state_q == IDLE) && (!out_valid || out_ready) && !flush;
  assign xfer     = in_valid && in_ready;

  // Next state and output-slot refill (direct ALU/branch or completed memory op).
  always_comb begin
    state_d   = state_q;
    slot_load = 1'b0;
    slot_d    = {(cls == CLS_BRANCH) ? result_in : pc_in,
                 instr_in, result_in, store_data_in, flags_in};
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (is_mem) state_d   = MEM;
          else        slot_load = 1'b1;
        end
      end
      MEM: begin
        if (mem_ack) begin
          slot_d = {pend_pc_q, pend_instr_q, pend_load_q ? mem_rdata : mem_addr,
                    pend_sd_q, pend_flags_q};
          if (discard_q || flush) begin
            state_d = IDLE;
          end else begin
            slot_load = 1'b1;
            state_d   = out_ready ? IDLE : HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, post-reset enable and flush-while-in-MEM discard marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      alive_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (state_q == MEM) begin
        if (mem_ack)    discard_q <= 1'b0;
        else if (flush) discard_q <= 1'b1;
      end
    end
  end

  // Memory request: launched on a load/store transfer, held until acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (xfer && is_mem) begin
      mem_req   <= 1'b1;
      mem_we    <= (cls == CLS_STORE);
      mem_addr  <= result_in;
      mem_wdata <= store_data_in;
    end else if ((state_q == MEM) && mem_ack) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end
  end

  // Instruction context parked while its memory access is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_load_q  <= 1'b0;
      pend_pc_q    <= '0;
      pend_instr_q <= '0;
      pend_sd_q    <= '0;
      pend_flags_q <= '0;
    end else if (xfer && is_mem) begin
      pend_load_q  <= (cls == CLS_LOAD);
      pend_pc_q    <= pc_in;
      pend_instr_q <= instr_in;
      pend_sd_q    <= store_data_in;
      pend_flags_q <= flags_in;
    end
  end

  pipe_reg #(.W(PAY_W)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (slot_load),
    .flush     (flush),
    .out_ready (out_ready),
    .in_data   (slot_d),
    .out_valid (out_valid),
    .out_data  (slot_q)
  );

  assign {pc_out, instr_out, result_out, store_data_out, flags_out} = slot_q;

endmodule

// File: doc/stage_ma_hs.md
STAGE_MA_HS -- requirements
Module: stage_ma_hs

Interface
REQ-001 SHALL have parameter DATA_W, default 24, width of pc, instruction, result, store data and memory address/data.
REQ-002 SHALL have parameter FLAGS_W, default 4, width of the flags bus.
REQ-003 SHALL have parameter OPC_W, default 8, opcode field width, taken from instruction bits [DATA_W-1 : DATA_W-OPC_W].
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous and active-low.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- flush  in  1  discard the held/in-flight instruction.
- pc_in, instr_in, result_in, store_data_in  in  DATA_W each  execute-stage outputs.
- flags_in  in  FLAGS_W  execute-stage flags.
- out_valid  out  1  output register holds a valid instruction.
- out_ready  in  1  downstream accepts this cycle.
- pc_out, instr_out, result_out, store_data_out  out  DATA_W each  latched results.
- flags_out  out  FLAGS_W  latched flags.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr, mem_wdata  out  DATA_W each  request address and store data.
- mem_ack  in  1  memory completes the request (1 cycle).
- mem_rdata  in  DATA_W  load data, valid with mem_ack.

Function
REQ-005 SHALL treat LD, LDi as loads; ST, STi as stores; BCC, BCCi, BCCis, SRBCC as branches; every other opcode as ALU.
REQ-006 SHALL implement states IDLE, MEM, HOLD.
REQ-007 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-008 Transfer occurs when in_valid && in_ready; without transfer, internal state SHALL be unchanged except as set by REQ-009..REQ-016.
REQ-009 ALU/branch transfer: next cycle out_valid=1; pc_out = result_in for branches, pc_in otherwise; remaining outputs = inputs (latency 1).
REQ-010 Load/store transfer: next cycle state=MEM, mem_req=1, mem_addr=result_in, mem_we=1 for stores, mem_wdata=store_data_in; mem_addr, mem_wdata and mem_we SHALL be stable while mem_req=1.
REQ-011 In MEM on mem_ack: mem_req deasserts next cycle; out_valid=1; result_out = mem_rdata for loads, address for stores; state -> HOLD if the downstream slot is still occupied, else IDLE.
REQ-012 mem_ack while mem_req=0 SHALL be ignored.
REQ-013 While out_valid && !out_ready, all out_* buses SHALL be held stable.
REQ-014 out_valid SHALL clear on out_ready unless a new transfer or mem_ack refills it the same cycle (back-to-back, zero bubbles for ALU ops).
REQ-015 flush SHALL clear out_valid next cycle; flush in MEM SHALL keep mem_req until mem_ack (no retraction), then discard the result and return to IDLE.
REQ-016 mem_addr and mem_wdata SHALL be 0 whenever mem_req=0.
REQ-017 Throughput: 1 ALU instruction/cycle; a memory instruction occupies the stage for (ack latency + 1) cycles.

Reset
REQ-018 rst low SHALL asynchronously force state=IDLE and every output (including in_ready and mem_req) to 0; in_ready may assert from the first clock after release.
REQ-019 Reset during MEM SHALL abandon the request; the memory model must accept the dropped request.

Structure
REQ-020 Opcode constants, OPC_W and the state enum SHALL live in the shared opcode package/header used by all pipeline stages.
REQ-021 The output register slice with valid/ready hold SHALL be a sub-module named pipe_reg, parametrised by payload width.

Verification
REQ-022 ALU ops ADD at pc=0x000010, 0x000011, out_ready=1 -> out_valid on consecutive cycles, pc_out 0x000010 then 0x000011.
REQ-023 BCCi with pc_in=0x000020, result_in=0x000100 -> pc_out=0x000100.
REQ-024 LD, result_in=0x0000A0, mem_ack after 3 cycles with mem_rdata=0x123456 -> mem_addr=0x0000A0 stable for 3 cycles, result_out=0x123456, in_ready low throughout.
REQ-025 STi, addr 0x000040, data 0xABCDEF, out_ready=0 for 4 cycles -> mem_we=1, mem_wdata=0xABCDEF; outputs held; in_ready=0 until out_ready.
REQ-026 flush in MEM, ack 2 cycles later -> mem_req held to ack, out_valid stays 0, next instruction accepted.
REQ-027 rst low mid-MEM -> mem_req and out_valid 0 immediately without a clock edge; DATA_W=32 build repeats REQ-024 with 32-bit values.
